// File: rtl/cpu_pkg.sv
// Shared RV decode constants: instruction field positions and load funct3 encodings.
package cpu_pkg;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/regfile_btn_ctrl_if.sv
// Core-side register file bus: decode input, write-back and the two read ports.
interface regfile_btn_ctrl_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instr;
  logic            reg_write;
  logic            mem_to_reg;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  modport master (
    output instr, reg_write, mem_to_reg, wr_data,
    input  rdata1, rdata2
  );

  modport slave (
    input  instr, reg_write, mem_to_reg, wr_data,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_btn_ctrl_load_ext.sv
// Load-data sign/zero extension; transparent unless the write-back comes from memory.
module load_ext
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            mem_to_reg,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = data;
    if (mem_to_reg) begin
      unique case (funct3)
        F3_LB:   ext = XLEN'($signed(data[7:0]));
        F3_LH:   ext = XLEN'($signed(data[15:0]));
        F3_LW:   ext = XLEN'($signed(data[31:0]));
        F3_LBU:  ext = XLEN'(data[7:0]);
        F3_LHU:  ext = XLEN'(data[15:0]);
        F3_LWU:  ext = XLEN'(data[31:0]);
        default: ext = data;
      endcase
    end
  end

endmodule

// File: rtl/regfile_btn_ctrl.sv
// Integer register file with load extension, write forwarding and sticky button flags
// mapped onto registers BTN_BASE..BTN_BASE+NBTN-1.
module regfile_btn_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NBTN     = 3,
  parameter int BTN_BASE = 21,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_btn_ctrl_if.slave   bus,
  input  logic [NBTN-1:0]     btn_in,
  output logic [NBTN-1:0]     btn_flags
);

  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] wr_ext;
  logic [XLEN-1:0] regs [NREG];
  logic [NBTN-1:0] rise;
  logic            wr_en;
  logic            unused_instr;

  assign rd     = bus.instr[RD_LSB  +: AW];
  assign rs1    = bus.instr[RS1_LSB +: AW];
  assign rs2    = bus.instr[RS2_LSB +: AW];
  assign funct3 = bus.instr[F3_LSB  +: 3];
  assign wr_en  = bus.reg_write && (rd != '0);
  assign unused_instr = ^bus.instr;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3     (funct3),
    .mem_to_reg (bus.mem_to_reg),
    .data       (bus.wr_data),
    .ext        (wr_ext)
  );

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        s3 <= 1'b0;
      end else begin
        s1 <= btn_in[g];
        s2 <= s1;
        s3 <= s2;
      end
    end
    assign rise[g] = s2 & ~s3;
  end

  // Button rises are applied after the software write so a same-cycle collision leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
    end else begin
      if (wr_en) regs[rd] <= wr_ext;
      for (int i = 0; i < NBTN; i++) begin
        if (rise[i]) regs[AW'(BTN_BASE + i)] <= XLEN'(1);
      end
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    if (rs1 != '0) begin
      bus.rdata1 = (BYPASS != 0 && wr_en && rd == rs1) ? wr_ext : regs[rs1];
    end
    if (rs2 != '0) begin
      bus.rdata2 = (BYPASS != 0 && wr_en && rd == rs2) ? wr_ext : regs[rs2];
    end
  end

  always_comb begin
    btn_flags = '0;
    for (int i = 0; i < NBTN; i++) btn_flags[i] = regs[AW'(BTN_BASE + i)][0];
  end

endmodule

// File: tb/tb_regfile_btn_ctrl.sv
// Directed bench for regfile_btn_ctrl: extension, forwarding, x0 and button flag behaviour.
module tb_regfile_btn_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] btn_in;
  logic [2:0] btn_flags;
  int checks;
  int errors;

  regfile_btn_ctrl_if #(.XLEN(32)) bus ();

  regfile_btn_ctrl #(
    .XLEN(32), .NREG(32), .NBTN(3), .BTN_BASE(21), .BYPASS(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .btn_in    (btn_in),
    .btn_flags (btn_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [2:0] f3,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, rd, 7'b0000011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [2:0] f3, input logic m2r,
                    input logic [31:0] d);
    bus.instr      = mk(rd, f3, 5'd0, 5'd0);
    bus.mem_to_reg = m2r;
    bus.wr_data    = d;
    bus.reg_write  = 1'b1;
    tick(1);
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
  endtask

  task automatic rd1(input string tag, input logic [4:0] rs, input logic [31:0] exp);
    bus.instr = mk(5'd0, 3'd0, rs, 5'd0);
    #1;
    check(tag, bus.rdata1, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    btn_in = 3'b000;
    bus.instr      = 32'h0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.wr_data    = 32'h0;
    #2 reset = 1'b0;
    tick(2);

    for (int i = 0; i < 32; i++) begin
      bus.instr = mk(5'd0, 3'd0, 5'(i), 5'(31 - i));
      #1;
      check($sformatf("rst_rd1_%0d", i), bus.rdata1, 32'h0);
      check($sformatf("rst_rd2_%0d", i), bus.rdata2, 32'h0);
    end
    check("rst_flags", 32'(btn_flags), 32'h0);
    reset = 1'b1;
    tick(1);

    wr(5'd5, 3'b000, 1'b1, 32'h0000_00F0);
    rd1("lb_neg", 5'd5, 32'hFFFF_FFF0);
    wr(5'd5, 3'b100, 1'b1, 32'h0000_00F0);
    rd1("lbu", 5'd5, 32'h0000_00F0);
    wr(5'd5, 3'b001, 1'b1, 32'h0001_8001);
    rd1("lh_neg", 5'd5, 32'hFFFF_8001);
    wr(5'd5, 3'b101, 1'b1, 32'h0001_8001);
    rd1("lhu", 5'd5, 32'h0000_8001);
    wr(5'd5, 3'b010, 1'b1, 32'h8000_0000);
    rd1("lw_pass", 5'd5, 32'h8000_0000);
    wr(5'd6, 3'b000, 1'b0, 32'h0000_1234);
    rd1("alu_addi", 5'd6, 32'h0000_1234);
    wr(5'd8, 3'b000, 1'b0, 32'hFFFF_FF80);
    rd1("alu_no_ext", 5'd8, 32'hFFFF_FF80);

    bus.instr = mk(5'd0, 3'd0, 5'd0, 5'd0);
    bus.wr_data = 32'hDEAD_BEEF;
    bus.reg_write = 1'b1;
    #1 check("x0_fwd", bus.rdata1, 32'h0);
    tick(1);
    bus.reg_write = 1'b0;
    rd1("x0_after", 5'd0, 32'h0);

    bus.instr = mk(5'd7, 3'd0, 5'd7, 5'd7);
    bus.wr_data = 32'h0000_0055;
    bus.reg_write = 1'b1;
    #1 check("byp_rd1", bus.rdata1, 32'h0000_0055);
    check("byp_rd2", bus.rdata2, 32'h0000_0055);
    tick(1);
    bus.reg_write = 1'b0;
    rd1("byp_stored", 5'd7, 32'h0000_0055);

    bus.instr = mk(5'd9, 3'b000, 5'd0, 5'd9);
    bus.wr_data = 32'h0000_0080;
    bus.mem_to_reg = 1'b1;
    bus.reg_write = 1'b1;
    #1 check("byp_ext", bus.rdata2, 32'hFFFF_FF80);
    tick(1);
    bus.reg_write = 1'b0;
    bus.mem_to_reg = 1'b0;

    btn_in = 3'b010;
    tick(2);
    check("btn_lat2", 32'(btn_flags), 32'h0);
    tick(1);
    check("btn_lat3", 32'(btn_flags), 32'h2);
    rd1("btn_reg22", 5'd22, 32'h1);
    wr(5'd22, 3'b000, 1'b0, 32'h0);
    check("btn_clr", 32'(btn_flags), 32'h0);
    tick(3);
    check("btn_held", 32'(btn_flags), 32'h0);
    btn_in = 3'b000;
    tick(3);
    btn_in = 3'b010;
    tick(3);
    check("btn_repress", 32'(btn_flags), 32'h2);

    btn_in = 3'b110;
    tick(2);
    bus.instr = mk(5'd23, 3'd0, 5'd23, 5'd0);
    bus.wr_data = 32'h0;
    bus.reg_write = 1'b1;
    #1 check("coll_fwd", bus.rdata1, 32'h0);
    check("coll_pre", 32'(btn_flags), 32'h2);
    tick(1);
    bus.reg_write = 1'b0;
    check("coll_flags", 32'(btn_flags), 32'h6);
    rd1("coll_reg23", 5'd23, 32'h1);

    btn_in = 3'b000;
    tick(3);
    wr(5'd22, 3'b000, 1'b0, 32'h0);
    wr(5'd23, 3'b000, 1'b0, 32'h0);
    check("clr_all", 32'(btn_flags), 32'h0);
    btn_in = 3'b111;
    tick(3);
    check("simul", 32'(btn_flags), 32'h7);

    bus.instr = mk(5'd10, 3'd0, 5'd5, 5'd0);
    bus.wr_data = 32'h0000_ABCD;
    bus.reg_write = 1'b1;
    #1 reset = 1'b0;
    btn_in = 3'b000;
    #1 check("rst_flags_now", 32'(btn_flags), 32'h0);
    check("rst_reg5", bus.rdata1, 32'h0);
    tick(1);
    bus.reg_write = 1'b0;
    reset = 1'b1;
    tick(1);
    rd1("rst_drop_wr", 5'd10, 32'h0);
    rd1("rst_reg7", 5'd7, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_btn_ctrl.md
Name: regfile_btn_ctrl

Overview:
- Parametrised integer register file for the single-cycle RV32I/RV64I core.
- Decodes rs1/rs2/rd/funct3 from the instruction and provides two asynchronous read ports and one synchronous write port.
- Applies load sign/zero extension only when the write-back source is memory, and returns x0 as zero.
- Captures board buttons as sticky, software-clearable flags in mapped registers, using synchronisers and edge detection.

Parameters:
- XLEN, 32, data width; only 32 or 64 are legal.
- NREG, 32, number of registers; power of two, max 32; AW = clog2(NREG).
- NBTN, 3, number of button inputs.
- BTN_BASE, 21, register index of button 0; button i maps to BTN_BASE+i; BTN_BASE+NBTN-1 < NREG and BTN_BASE > 0.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction; rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20]; only the low AW bits of each address are used.
- reg_write  in  1  write enable for rd.
- mem_to_reg  in  1  1 = wr_data is load data, so extension applies.
- wr_data  in  XLEN  write-back data.
- btn_in  in  NBTN  raw asynchronous button levels, active-high.
- rdata1  out  XLEN  value of rs1.
- rdata2  out  XLEN  value of rs2.
- btn_flags  out  NBTN  bit 0 of each mapped button register.

Behaviour:
- Reset (reset=0, asynchronous): all registers, synchroniser flops and edge flops are cleared to 0. Consequently rdata1, rdata2 and btn_flags read 0. Reset asserted mid-write discards that write.
- Reads are combinational.
  - Address 0 always returns 0.
  - Otherwise the stored value is returned.
  - If BYPASS=1, reg_write=1, rd==rs and rd!=0, the extended write value is returned instead.
- Extension is applied only when mem_to_reg=1; when mem_to_reg=0, wr_data is written unmodified for any funct3. Load extension by funct3:
  - 000 (lb): sign-extend [7:0].
  - 001 (lh): sign-extend [15:0].
  - 010 (lw): sign-extend [31:0] when XLEN=64; pass through when XLEN=32.
  - 011 (ld): pass through.
  - 100 (lbu): zero-extend [7:0].
  - 101 (lhu): zero-extend [15:0].
  - 110 (lwu): zero-extend [31:0].
  - 111: pass through.
- Writes: on posedge with reg_write=1 and rd!=0, reg[rd] takes the extended value. Writes to x0 are dropped.
- Button path, per bit:
  - Two-flop synchroniser (s1, s2), then a previous-value flop s3.
  - rise = s2 & ~s3.
  - rise=1 sets reg[BTN_BASE+i] to 1 (zero-extended) at that posedge.
  - Latency: btn_in high before edge k; s1 at k, s2 at k+1, rise during cycle k+1, flag visible after edge k+2, i.e. 3 edges.
- Held buttons set the flag once only; release followed by a new press sets it again.
- Flag clearing: software clears a flag by writing the mapped register; any written value is stored.
- Collision: rise and a software write to the same mapped register in the same cycle → the button wins and the register becomes 1. The forwarded read value in that cycle is the software data.
- Simultaneous rises on several buttons set all of their flags in the same cycle.
- btn_flags[i] = reg[BTN_BASE+i][0], registered state, never bypassed.

Decomposition:
- Shared package cpu_pkg holds:
  - funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU);
  - field position constants RD_LSB, RS1_LSB, RS2_LSB, F3_LSB.
- One sub-module, load_ext: combinational, parameter XLEN, inputs funct3, mem_to_reg and data, output the extended value.
- The synchroniser and edge-detect logic live in a generate loop inside the top block; no separate module.

Test Plan:
- Reset then read all addresses → every read is 0; btn_flags=000.
- mem_to_reg=1, funct3=000, wr_data=0x000000F0, rd=5 → reg5=0xFFFFFFF0. Repeat with funct3=100 → reg5=0x000000F0.
- mem_to_reg=0, funct3=000 (addi), wr_data=0x00001234, rd=6 → reg6=0x00001234, no truncation.
- Write 0xDEADBEEF to rd=0 → rs1=0 reads 0. Write 0x55 to rd=7 with rs1=7 in the same cycle (BYPASS=1) → rdata1=0x55 before the edge.
- btn_in[1] pulse held 5 cycles → reg22=1 exactly 3 edges after the first sample, btn_flags=010. Write 0 to reg22 → flag 0. Keep holding the button → flag stays 0.
- Button rise and software write of 0 to reg23 in the same cycle → reg23=1. Assert reset mid-sequence → all flags 0 immediately.
